// File: rtl/cmp_arbiter_pkg.sv
// Shared definitions for the two-requester compare arbiter:
// result flag bit positions and the response-register state.
package cmp_arbiter_pkg;

    localparam int FLAG_SLT = 3;
    localparam int FLAG_EQ  = 2;
    localparam int FLAG_ULT = 1;
    localparam int FLAG_OVF = 0;
    localparam int FLAG_W   = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/cmp_flags_unit.sv
// Combinational subtract/compare: a-b plus signed/unsigned
// less-than, equality and signed-overflow flags.
module cmp_flags_unit
    import cmp_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]  i_a,
    input  logic [WIDTH-1:0]  i_b,
    output logic [WIDTH-1:0]  o_diff,
    output logic [FLAG_W-1:0] o_flags
);

    logic [WIDTH:0] w_sub;
    logic           w_ovf;

    // Extra MSB of the widened subtraction is the unsigned borrow
    assign w_sub  = {1'b0, i_a} - {1'b0, i_b};
    assign o_diff = w_sub[WIDTH-1:0];
    assign w_ovf  = (i_a[WIDTH-1] != i_b[WIDTH-1]) &&
                    (w_sub[WIDTH-1] != i_a[WIDTH-1]);

    always_comb begin
        o_flags           = '0;
        o_flags[FLAG_SLT] = $signed(i_a) < $signed(i_b);
        o_flags[FLAG_EQ]  = (i_a == i_b);
        o_flags[FLAG_ULT] = w_sub[WIDTH];
        o_flags[FLAG_OVF] = w_ovf;
    end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter feeding a one-deep compare result register.
// Define CMP_ARBITER_STATS_EN to add per-requester grant counters.
module cmp_arbiter
    import cmp_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    output logic              req1_ready,
`ifdef CMP_ARBITER_STATS_EN
    output logic [15:0]       grant_cnt0,
    output logic [15:0]       grant_cnt1,
`endif
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [WIDTH-1:0]  rsp_diff,
    output logic [FLAG_W-1:0] rsp_flags
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_last;
    logic               r_id;
    logic [WIDTH-1:0]   r_diff;
    logic [FLAG_W-1:0]  r_flags;

    logic               w_ok;
    logic               w_pick1;
    logic               w_g0;
    logic               w_g1;
    logic               w_grant;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [WIDTH-1:0]   w_diff;
    logic [FLAG_W-1:0]  w_flags;

    // rst_n gating keeps both readys low throughout reset
    assign w_ok    = rst_n && ((r_state == EMPTY) || rsp_ready);
    assign w_pick1 = req1_valid && (!req0_valid || !r_last);
    assign w_g0    = w_ok && req0_valid && !w_pick1;
    assign w_g1    = w_ok && w_pick1;
    assign w_grant = w_g0 || w_g1;

    assign w_a = w_pick1 ? req1_a : req0_a;
    assign w_b = w_pick1 ? req1_b : req0_b;

    cmp_flags_unit #(
        .WIDTH (WIDTH)
    ) u_flags (
        .i_a     (w_a),
        .i_b     (w_b),
        .o_diff  (w_diff),
        .o_flags (w_flags)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (w_grant) begin
            w_state_nxt = FULL;
        end else if (r_state == FULL && rsp_ready) begin
            w_state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_last  <= 1'b1;
            r_id    <= 1'b0;
            r_diff  <= '0;
            r_flags <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_last  <= w_pick1;
                r_id    <= w_pick1;
                r_diff  <= w_diff;
                r_flags <= w_flags;
            end
        end
    end

`ifdef CMP_ARBITER_STATS_EN
    logic [15:0] r_cnt0;
    logic [15:0] r_cnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_g0) r_cnt0 <= r_cnt0 + 16'd1;
            if (w_g1) r_cnt1 <= r_cnt1 + 16'd1;
        end
    end

    assign grant_cnt0 = r_cnt0;
    assign grant_cnt1 = r_cnt1;
`endif

    assign req0_ready = w_g0;
    assign req1_ready = w_g1;
    assign rsp_valid  = (r_state == FULL);
    assign rsp_id     = r_id;
    assign rsp_diff   = r_diff;
    assign rsp_flags  = r_flags;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed-vector bench for cmp_arbiter; the stats counters are
// exercised only when CMP_ARBITER_STATS_EN is defined.
module tb_cmp_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        req1_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_diff;
    logic [3:0]  rsp_flags;
`ifdef CMP_ARBITER_STATS_EN
    logic [15:0] grant_cnt0;
    logic [15:0] grant_cnt1;
`endif

    int n_total;
    int n_bad;

    cmp_arbiter #(
        .WIDTH (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
`ifdef CMP_ARBITER_STATS_EN
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1),
`endif
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_diff   (rsp_diff),
        .rsp_flags  (rsp_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rsp(input string tag, input logic id,
                           input logic [31:0] diff,
                           input logic [3:0] flags);
        check({tag, "_v"}, 64'(rsp_valid), 64'd1);
        check({tag, "_id"}, 64'(rsp_id), 64'(id));
        check({tag, "_diff"}, 64'(rsp_diff), 64'(diff));
        check({tag, "_flg"}, 64'(rsp_flags), 64'(flags));
    endtask

    logic exp_ids [4];

    initial begin
        n_total = 0;
        n_bad   = 0;
        exp_ids[0] = 1'b1;
        exp_ids[1] = 1'b0;
        exp_ids[2] = 1'b1;
        exp_ids[3] = 1'b0;

        rst_n      = 1'b0;
        req0_valid = 1'b1;
        req0_a     = 32'd5;
        req0_b     = 32'd7;
        req1_valid = 1'b0;
        req1_a     = '0;
        req1_b     = '0;
        rsp_ready  = 1'b1;
        #1;
        check("rst_valid", 64'(rsp_valid), 64'd0);
        check("rst_id", 64'(rsp_id), 64'd0);
        check("rst_diff", 64'(rsp_diff), 64'd0);
        check("rst_flags", 64'(rsp_flags), 64'd0);
        check("rst_rdy0", 64'(req0_ready), 64'd0);
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // single request: 5 - 7
        check("single_rdy0", 64'(req0_ready), 64'd1);
        check("single_rdy1", 64'(req1_ready), 64'd0);
        tick();
        chk_rsp("single", 1'b0, 32'hFFFF_FFFE, 4'b1010);
        req0_valid = 1'b0;
        tick();
        check("drain_empty", 64'(rsp_valid), 64'd0);
        check("drain_hold", 64'(rsp_diff), 64'hFFFF_FFFE);

        // tie: last grant was 0, so requester 1 leads
        req0_valid = 1'b1;
        req0_a     = 32'd10;
        req0_b     = 32'd3;
        req1_valid = 1'b1;
        req1_a     = 32'd3;
        req1_b     = 32'd10;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("tie_rdy1", 64'(req1_ready), 64'(exp_ids[i]));
            check("tie_rdy0", 64'(req0_ready), 64'(!exp_ids[i]));
            tick();
            if (exp_ids[i])
                chk_rsp("tie", 1'b1, 32'hFFFF_FFF9, 4'b1010);
            else
                chk_rsp("tie", 1'b0, 32'd7, 4'b0000);
        end

        // backpressure with both still requesting
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_rdy0", 64'(req0_ready), 64'd0);
            check("bp_rdy1", 64'(req1_ready), 64'd0);
            tick();
            chk_rsp("bp", 1'b0, 32'd7, 4'b0000);
        end
        rsp_ready = 1'b1;
        #1;
        check("rel_rdy1", 64'(req1_ready), 64'd1);
        check("rel_rdy0", 64'(req0_ready), 64'd0);
        tick();
        chk_rsp("rel", 1'b1, 32'hFFFF_FFF9, 4'b1010);

        // overflow, equal, unsigned-only less-than
        req1_valid = 1'b0;
        req0_a     = 32'h8000_0000;
        req0_b     = 32'd1;
        tick();
        chk_rsp("ovf", 1'b0, 32'h7FFF_FFFF, 4'b1001);
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_a     = 32'hFFFF_FFFF;
        req1_b     = 32'hFFFF_FFFF;
        tick();
        chk_rsp("eq", 1'b1, 32'd0, 4'b0100);
        req1_valid = 1'b0;
        req0_valid = 1'b1;
        req0_a     = 32'd1;
        req0_b     = 32'hFFFF_FFFF;
        tick();
        chk_rsp("ult", 1'b0, 32'd2, 4'b0010);

        // reset while FULL, mid-cycle
        req0_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_valid", 64'(rsp_valid), 64'd0);
        check("mrst_diff", 64'(rsp_diff), 64'd0);
        check("mrst_flags", 64'(rsp_flags), 64'd0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("mrst_norsp", 64'(rsp_valid), 64'd0);
        req0_valid = 1'b1;
        req0_a     = 32'd9;
        req0_b     = 32'd9;
        req1_valid = 1'b1;
        req1_a     = 32'd0;
        req1_b     = 32'd1;
        #1;
        check("mrst_rdy0", 64'(req0_ready), 64'd1);
        check("mrst_rdy1", 64'(req1_ready), 64'd0);
        tick();
        chk_rsp("mrst_tie", 1'b0, 32'd0, 4'b0100);

`ifdef CMP_ARBITER_STATS_EN
        req0_valid = 1'b0;
        tick();
        check("cnt1_one", 64'(grant_cnt1), 64'd1);
        repeat (65535) tick();
        req1_valid = 1'b0;
        check("cnt1_wrap", 64'(grant_cnt1), 64'd0);
        check("cnt0_keep", 64'(grant_cnt0), 64'd1);
`endif

        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        check("end_empty", 64'(rsp_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
